mantissa_multiplier_unit: RTL and testbench

- Sequential unsigned mantissa multiplier. It is the callee (responder) on the Multi_* handshake driven by the FPU multiplication control block.
- It accepts two 24-bit mantissas with the hidden bit in place and computes the exact 48-bit product over WIDTH cycles using radix-2 shift-add.
- It returns the product, a 3-bit exception code and an acknowledge under a four-phase valid/ack protocol.

---
 rtl/mantissa_multiplier_unit.sv | 125 ++++++++++++
 tb/tb_mantissa_multiplier_unit.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mantissa_multiplier_unit.sv
// Sequential unsigned mantissa multiplier. It uses radix-2 shift-add over
// WIDTH cycles and answers the FPU control block on the Multi_* four-phase
// valid/ack handshake.
//
// Handshake: the caller raises Multi_valid with the operands held stable and
// keeps it high until Multi_ack=1. Ack, product and exception code then stay
// constant until the first edge that samples Multi_valid=0. That edge clears
// them and returns the unit to IDLE. Dropping Multi_valid before ack aborts
// the operation without an ack. A new request must therefore see Multi_valid
// low for at least one edge.
module mantissa_multiplier_unit #(
  parameter int WIDTH         = 24,
  parameter int ZERO_SHORTCUT = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [WIDTH-1:0]     Multi_datain1,
  input  logic [WIDTH-1:0]     Multi_datain2,
  input  logic                 Multi_valid,
  output logic [2*WIDTH-1:0]   Multi_dataout,
  output logic [2:0]           Multi_Exc,
  output logic                 Multi_ack,
  output logic                 Busy,
  output logic [1:0]           dbg_state_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q;
  logic [WIDTH-1:0]     mcand_q;    // latched multiplicand
  logic [WIDTH-1:0]     mplier_q;   // multiplier; low product bits shift in from the top
  logic [WIDTH:0]       acc_q;      // upper accumulator half, one extra bit for the carry
  logic [CW-1:0]        cnt_q;
  logic [2*WIDTH-1:0]   dataout_q;
  logic [2:0]           exc_q;
  logic                 ack_q;
  logic                 busy_q;
  logic [WIDTH:0]       sum_d;

  // Partial sum for this iteration. acc_q never exceeds WIDTH bits after a shift, so this cannot overflow.
  always_comb begin
    sum_d = acc_q;
    if (mplier_q[0]) sum_d = acc_q + {1'b0, mcand_q};
  end

  // Control FSM plus shift-add datapath. All outputs are registered here.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      dataout_q <= '0;
      exc_q     <= 3'b000;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (Multi_valid) begin
            mcand_q  <= Multi_datain1;
            mplier_q <= Multi_datain2;
            acc_q    <= '0;
            cnt_q    <= '0;
            if ((ZERO_SHORTCUT != 0) && ((Multi_datain1 == '0) || (Multi_datain2 == '0))) begin
              state_q   <= S_DONE;
              dataout_q <= '0;
              exc_q     <= 3'b110;
              ack_q     <= 1'b1;
            end else begin
              state_q <= S_CALC;
              busy_q  <= 1'b1;
            end
          end
        end
        S_CALC: begin
          if (!Multi_valid) begin
            // Caller withdrew the request: abandon silently. Outputs are still zero.
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            acc_q    <= {1'b0, sum_d[WIDTH:1]};
            mplier_q <= {sum_d[0], mplier_q[WIDTH-1:1]};
            cnt_q    <= cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) begin
              // Final shifted {sum, multiplier} is the complete product.
              dataout_q <= {sum_d, mplier_q[WIDTH-1:1]};
              exc_q     <= 3'b000;
              ack_q     <= 1'b1;
              busy_q    <= 1'b0;
              state_q   <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (!Multi_valid) begin
            dataout_q <= '0;
            exc_q     <= 3'b000;
            ack_q     <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          ack_q   <= 1'b0;
        end
      endcase
    end
  end

  assign Multi_dataout = dataout_q;
  assign Multi_Exc     = exc_q;
  assign Multi_ack     = ack_q;
  assign Busy          = busy_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_mantissa_multiplier_unit.sv
// Bench for mantissa_multiplier_unit. It uses directed and random operands
// and checks every result against a plain arithmetic product.
module tb_mantissa_multiplier_unit;

  localparam int W = 24;

  logic          CLK;
  logic          RST;
  logic [W-1:0]  d1;
  logic [W-1:0]  d2;
  logic          valid;
  logic [2*W-1:0] dout;
  logic [2:0]    exc;
  logic          ack;
  logic          busy;
  logic [1:0]    dbg_state;

  int check_cnt = 0;
  int pass_cnt  = 0;

  logic [2*W-1:0] exp_q[$];

  mantissa_multiplier_unit #(.WIDTH(W), .ZERO_SHORTCUT(1)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .Multi_datain1 (d1),
    .Multi_datain2 (d2),
    .Multi_valid   (valid),
    .Multi_dataout (dout),
    .Multi_Exc     (exc),
    .Multi_ack     (ack),
    .Busy          (busy),
    .dbg_state_o   (dbg_state)
  );

  // Clock and reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: exact unsigned product.
  function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] wa;
    logic [2*W-1:0] wb;
    wa = {{W{1'b0}}, a};
    wb = {{W{1'b0}}, b};
    return wa * wb;
  endfunction

  // Driver: raise a request and wait for ack. Leaves valid high.
  // Latency counts edges from the sampling edge to ack visibility.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       output int lat, output int busy_n, output bit timed_out);
    @(negedge CLK);
    d1 = a;
    d2 = b;
    valid = 1'b1;
    lat = 0;
    busy_n = 0;
    timed_out = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge CLK);
      #1;
      if (i == 0) begin
        // Operands are latched; scribbling on the inputs must not matter.
        d1 = W'($urandom);
        d2 = W'($urandom);
      end
      if (busy) busy_n++;
      if (ack) begin
        lat = i + 1;
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  // Driver: drop valid and step to just after the release edge.
  task automatic release_req();
    @(negedge CLK);
    valid = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    valid = 1'b0;
    d1 = '0;
    d2 = '0;
    repeat (3) @(posedge CLK);
    #1;
    check_cnt++;
    if ({ack, busy, exc, dout, dbg_state} !== '0)
      $display("FAIL reset_outputs: got ack=%0b busy=%0b exc=%03b dout=%h st=%0d, want all 0",
               ack, busy, exc, dout, dbg_state);
    else pass_cnt++;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_basic();
    int lat, bn;
    bit to;
    do_op(24'h800000, 24'h800000, lat, bn, to);
    check_cnt++;
    if (to) $display("FAIL basic_timeout: no ack within 100 cycles");
    else pass_cnt++;
    check_cnt++;
    if (lat !== 25) $display("FAIL basic_latency: got %0d want 25", lat);
    else pass_cnt++;
    check_cnt++;
    if (dout !== 48'h400000000000) $display("FAIL basic_product: got %h want 400000000000", dout);
    else pass_cnt++;
    check_cnt++;
    if (exc !== 3'b000) $display("FAIL basic_exc: got %03b want 000", exc);
    else pass_cnt++;
    check_cnt++;
    if (bn !== 24) $display("FAIL basic_busy_cycles: got %0d want 24", bn);
    else pass_cnt++;
    release_req();
    check_cnt++;
    if ({ack, exc, dout} !== '0) $display("FAIL basic_release: got ack=%0b exc=%03b dout=%h want 0", ack, exc, dout);
    else pass_cnt++;
  endtask

  task automatic test_products();
    logic [W-1:0] av[2];
    logic [W-1:0] bv[2];
    logic [2*W-1:0] want[2];
    int lat, bn;
    bit to;
    av[0] = 24'hFFFFFF; bv[0] = 24'hFFFFFF; want[0] = 48'hFFFFFE000001;
    av[1] = 24'hC00000; bv[1] = 24'hC00000; want[1] = 48'h900000000000;
    for (int i = 0; i < 2; i++) begin
      do_op(av[i], bv[i], lat, bn, to);
      check_cnt++;
      if (to || dout !== want[i]) $display("FAIL product_%0d: got %h want %h (timeout=%0b)", i, dout, want[i], to);
      else pass_cnt++;
      check_cnt++;
      if (i == 0 && dout[2*W-1] !== 1'b1) $display("FAIL product_msb: got %0b want 1", dout[2*W-1]);
      else pass_cnt++;
      release_req();
    end
  endtask

  task automatic test_zero();
    int lat, bn;
    bit to;
    do_op(24'h000000, 24'h800000, lat, bn, to);
    check_cnt++;
    if (to || lat !== 1) $display("FAIL zero_latency: got %0d want 1 (timeout=%0b)", lat, to);
    else pass_cnt++;
    check_cnt++;
    if (dout !== '0 || exc !== 3'b110) $display("FAIL zero_result: got dout=%h exc=%03b want 0/110", dout, exc);
    else pass_cnt++;
    check_cnt++;
    if (bn !== 0) $display("FAIL zero_busy: got %0d busy cycles want 0", bn);
    else pass_cnt++;
    release_req();
  endtask

  task automatic test_back_to_back();
    int lat, bn;
    bit to;
    int bad;
    logic [2*W-1:0] want;
    want = ref_prod(24'hB40000, 24'h8C0000);
    do_op(24'hB40000, 24'h8C0000, lat, bn, to);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK);
      #1;
      if (ack !== 1'b1 || dout !== want || exc !== 3'b000) bad++;
    end
    check_cnt++;
    if (to || bad != 0) $display("FAIL hold_stable: %0d unstable cycles, dout=%h want %h", bad, dout, want);
    else pass_cnt++;
    release_req();
    check_cnt++;
    if (ack !== 1'b0 || dbg_state !== 2'd0) $display("FAIL hold_release: got ack=%0b st=%0d want 0/0", ack, dbg_state);
    else pass_cnt++;
    do_op(24'hA00000, 24'h900000, lat, bn, to);
    check_cnt++;
    if (to || lat !== 25 || dout !== 48'h5A0000000000)
      $display("FAIL back_to_back: got lat=%0d dout=%h want 25/5a0000000000", lat, dout);
    else pass_cnt++;
    release_req();
  endtask

  task automatic test_abort();
    int lat, bn;
    bit to;
    int acks;
    @(negedge CLK);
    d1 = 24'h812345;
    d2 = 24'hF00F0F;
    valid = 1'b1;
    repeat (13) @(negedge CLK);
    valid = 1'b0;
    acks = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge CLK);
      #1;
      if (ack || dout !== '0) acks++;
    end
    check_cnt++;
    if (acks != 0 || busy !== 1'b0) $display("FAIL abort_no_ack: got %0d bad cycles busy=%0b want 0/0", acks, busy);
    else pass_cnt++;
    do_op(24'h800000, 24'hC00000, lat, bn, to);
    check_cnt++;
    if (to || lat !== 25 || dout !== 48'h600000000000)
      $display("FAIL abort_next: got lat=%0d dout=%h want 25/600000000000", lat, dout);
    else pass_cnt++;
    release_req();
  endtask

  task automatic test_reset_mid();
    int lat, bn;
    bit to;
    @(negedge CLK);
    d1 = 24'hFFFFFF;
    d2 = 24'hABCDEF;
    valid = 1'b1;
    repeat (6) @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    check_cnt++;
    if ({ack, busy, exc, dout, dbg_state} !== '0)
      $display("FAIL reset_mid: got ack=%0b busy=%0b exc=%03b dout=%h st=%0d want all 0",
               ack, busy, exc, dout, dbg_state);
    else pass_cnt++;
    @(negedge CLK);
    RST = 1'b0;
    valid = 1'b0;
    do_op(24'h9ABCDE, 24'hC12345, lat, bn, to);
    check_cnt++;
    if (to || dout !== ref_prod(24'h9ABCDE, 24'hC12345))
      $display("FAIL reset_mid_next: got %h want %h", dout, ref_prod(24'h9ABCDE, 24'hC12345));
    else pass_cnt++;
    release_req();
  endtask

  task automatic test_random();
    int lat, bn;
    bit to;
    logic [W-1:0] a, b;
    logic [2*W-1:0] want;
    int want_lat;
    logic [2:0] want_exc;
    for (int n = 0; n < 12; n++) begin
      a = W'($urandom) | 24'h800000;
      b = W'($urandom) | 24'h800000;
      if ($urandom_range(0, 7) == 0) a = '0;
      if ($urandom_range(0, 7) == 0) b = '0;
      exp_q.push_back(ref_prod(a, b));
      want_lat = (a == '0 || b == '0) ? 1 : 25;
      want_exc = (a == '0 || b == '0) ? 3'b110 : 3'b000;
      do_op(a, b, lat, bn, to);
      want = exp_q.pop_front();
      check_cnt++;
      if (to || dout !== want || exc !== want_exc || lat !== want_lat)
        $display("FAIL random_%0d: %h x %h got dout=%h exc=%03b lat=%0d want %h/%03b/%0d",
                 n, a, b, dout, exc, lat, want, want_exc, want_lat);
      else pass_cnt++;
      release_req();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_products();
    test_zero();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
